// File: rtl/vctr_fetch_engine.sv
// Vector fetch engine: pops test-vector addresses, issues one fixed-length burst read
// per address and streams the returned words (optionally byte-swapped) into the vector FIFO.
module vctr_fetch_engine #(
  parameter int BURST_LEN       = 4,
  parameter int VCTR_FIFO_DEPTH = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run_program,
  input  logic        vector_byte_swap,
  input  logic        clear_error,
  input  logic [31:0] addr_fifo_dout,
  input  logic        addr_fifo_empty,
  output logic        addr_fifo_rd,
  input  logic [15:0] words_in_vctr_fifo,
  input  logic        vector_fifo_full,
  output logic [31:0] vctr_fifo_din,
  output logic        vctr_fifo_wr,
  output logic [31:0] master_addr,
  output logic [7:0]  master_len,
  output logic        master_rd,
  input  logic        master_ready,
  input  logic [31:0] master_data_in,
  input  logic        master_data_in_val,
  output logic        fetch_busy,
  output logic        fetch_error,
  output logic [31:0] addrs_consumed,
  output logic [31:0] words_fetched
);

  localparam logic [2:0]  ST_IDLE  = 3'd0;
  localparam logic [2:0]  ST_POP   = 3'd1;
  localparam logic [2:0]  ST_LATCH = 3'd2;
  localparam logic [2:0]  ST_REQ   = 3'd3;
  localparam logic [2:0]  ST_DATA  = 3'd4;
  localparam logic [7:0]  LAST_BEAT  = 8'(BURST_LEN - 1);
  localparam logic [31:0] FILL_LIMIT = 32'(VCTR_FIFO_DEPTH - BURST_LEN);

  function automatic logic [31:0] byte_swap(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  logic [2:0]  state_r;
  logic [2:0]  state_next_s;
  logic [7:0]  beat_cnt_r;
  logic        start_s;
  logic        addr_err_s;
  logic        beat_in_data_s;
  logic        wr_ok_s;
  logic        err_set_s;
  logic [31:0] wr_word_s;

  assign master_len = LAST_BEAT;

  // Next-state decode plus error and write qualification for the current cycle.
  always_comb begin
    start_s        = run_program && !addr_fifo_empty &&
                     ({16'd0, words_in_vctr_fifo} <= FILL_LIMIT);
    addr_err_s     = (state_r == ST_LATCH) && (addr_fifo_dout[1:0] != 2'b00);
    beat_in_data_s = master_data_in_val && (state_r == ST_DATA);
    wr_ok_s        = beat_in_data_s && !vector_fifo_full;
    // A beat outside DATA, a misaligned address, or a write into a full FIFO all flag an error.
    err_set_s      = addr_err_s ||
                     (master_data_in_val && (state_r != ST_DATA)) ||
                     (beat_in_data_s && vector_fifo_full);
    if (vector_byte_swap) begin
      wr_word_s = byte_swap(master_data_in);
    end else begin
      wr_word_s = master_data_in;
    end
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s) state_next_s = ST_POP;
        else         state_next_s = ST_IDLE;
      end
      ST_POP:  state_next_s = ST_LATCH;
      ST_LATCH: begin
        if (addr_err_s) state_next_s = ST_IDLE;
        else            state_next_s = ST_REQ;
      end
      ST_REQ: begin
        if (master_rd && master_ready) state_next_s = ST_DATA;
        else                           state_next_s = ST_REQ;
      end
      ST_DATA: begin
        if (beat_in_data_s && (beat_cnt_r == LAST_BEAT)) state_next_s = ST_IDLE;
        else                                             state_next_s = ST_DATA;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State, strobes, captured data, counters and the sticky error flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r        <= ST_IDLE;
      beat_cnt_r     <= 8'd0;
      addr_fifo_rd   <= 1'b0;
      master_rd      <= 1'b0;
      master_addr    <= 32'd0;
      vctr_fifo_wr   <= 1'b0;
      vctr_fifo_din  <= 32'd0;
      fetch_busy     <= 1'b0;
      fetch_error    <= 1'b0;
      addrs_consumed <= 32'd0;
      words_fetched  <= 32'd0;
    end else begin
      state_r      <= state_next_s;
      fetch_busy   <= (state_next_s != ST_IDLE);
      addr_fifo_rd <= (state_next_s == ST_POP);
      master_rd    <= (state_next_s == ST_REQ);
      vctr_fifo_wr <= wr_ok_s;

      if (state_next_s == ST_POP) begin
        addrs_consumed <= addrs_consumed + 32'd1;
      end else begin
        addrs_consumed <= addrs_consumed;
      end

      if (state_r == ST_LATCH) begin
        master_addr <= addr_fifo_dout;
      end else begin
        master_addr <= master_addr;
      end

      if (state_r == ST_REQ) begin
        beat_cnt_r <= 8'd0;
      end else if (beat_in_data_s) begin
        beat_cnt_r <= beat_cnt_r + 8'd1;
      end else begin
        beat_cnt_r <= beat_cnt_r;
      end

      if (wr_ok_s) begin
        vctr_fifo_din <= wr_word_s;
        words_fetched <= words_fetched + 32'd1;
      end else begin
        vctr_fifo_din <= vctr_fifo_din;
        words_fetched <= words_fetched;
      end

      if (err_set_s) begin
        fetch_error <= 1'b1;
      end else if (clear_error) begin
        fetch_error <= 1'b0;
      end else begin
        fetch_error <= fetch_error;
      end
    end
  end

endmodule

// File: tb/tb_vctr_fetch_engine.sv
// Scoreboard bench for vctr_fetch_engine: expected vector-FIFO words are queued as beats
// are driven and checked as the engine writes them.
module tb_vctr_fetch_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        run_program;
  logic        vector_byte_swap;
  logic        clear_error;
  logic [31:0] addr_fifo_dout = 32'd0;
  logic        addr_fifo_empty = 1'b1;
  logic        addr_fifo_rd;
  logic [15:0] words_in_vctr_fifo;
  logic        vector_fifo_full;
  logic [31:0] vctr_fifo_din;
  logic        vctr_fifo_wr;
  logic [31:0] master_addr;
  logic [7:0]  master_len;
  logic        master_rd;
  logic        master_ready;
  logic [31:0] master_data_in;
  logic        master_data_in_val;
  logic        fetch_busy;
  logic        fetch_error;
  logic [31:0] addrs_consumed;
  logic [31:0] words_fetched;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_pop   = 0;
  logic [31:0] addr_q[$];
  logic [31:0] exp_q[$];

  vctr_fetch_engine #(.BURST_LEN(4), .VCTR_FIFO_DEPTH(1024)) dut (
    .clk(clk), .reset(reset), .run_program(run_program),
    .vector_byte_swap(vector_byte_swap), .clear_error(clear_error),
    .addr_fifo_dout(addr_fifo_dout), .addr_fifo_empty(addr_fifo_empty),
    .addr_fifo_rd(addr_fifo_rd), .words_in_vctr_fifo(words_in_vctr_fifo),
    .vector_fifo_full(vector_fifo_full), .vctr_fifo_din(vctr_fifo_din),
    .vctr_fifo_wr(vctr_fifo_wr), .master_addr(master_addr), .master_len(master_len),
    .master_rd(master_rd), .master_ready(master_ready), .master_data_in(master_data_in),
    .master_data_in_val(master_data_in_val), .fetch_busy(fetch_busy),
    .fetch_error(fetch_error), .addrs_consumed(addrs_consumed), .words_fetched(words_fetched)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Address FIFO model: read data appears the cycle after the pop strobe.
  always @(negedge clk) begin
    if (addr_fifo_rd && (addr_q.size() > 0)) addr_fifo_dout = addr_q.pop_front();
    addr_fifo_empty = (addr_q.size() == 0);
  end

  // Write monitor: every vector-FIFO write must match the head of the scoreboard.
  always @(negedge clk) begin
    logic [31:0] e;
    if (reset) begin
      if (addr_fifo_rd) n_pop++;
      if (vctr_fifo_wr) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check_val("wr_data", vctr_fifo_din, e);
        end else begin
          check_val("wr_unexpected", 32'(vctr_fifo_wr), 32'd0);
        end
      end
    end
  end

  task automatic wait_rd(input int budget);
    int n = 0;
    while (!master_rd && (n < budget)) begin
      tick(1);
      n++;
    end
    check_val("rd_timeout", 32'(master_rd), 32'd1);
  endtask

  // Drive n back-to-back beats; the beat at drop_idx sees a full vector FIFO.
  task automatic send_burst(input logic [31:0] first, input int n, input int drop_idx);
    logic [31:0] d;
    for (int i = 0; i < n; i++) begin
      d = first + 32'(i) * 32'h1111_1111;
      master_data_in     = d;
      master_data_in_val = 1'b1;
      vector_fifo_full   = (i == drop_idx);
      if (i != drop_idx) begin
        if (vector_byte_swap) exp_q.push_back({d[7:0], d[15:8], d[23:16], d[31:24]});
        else                  exp_q.push_back(d);
      end
      tick(1);
    end
    master_data_in_val = 1'b0;
    vector_fifo_full   = 1'b0;
  endtask

  initial begin
    logic saw_rd;
    reset = 1'b0; run_program = 1'b0; vector_byte_swap = 1'b0; clear_error = 1'b0;
    words_in_vctr_fifo = 16'd0; vector_fifo_full = 1'b0; master_ready = 1'b0;
    master_data_in = 32'd0; master_data_in_val = 1'b0;
    tick(3);
    check_val("rst_busy", 32'(fetch_busy), 32'd0);
    check_val("rst_rd", 32'(master_rd), 32'd0);
    check_val("rst_wr", 32'(vctr_fifo_wr), 32'd0);
    check_val("rst_err", 32'(fetch_error), 32'd0);
    check_val("rst_len", 32'(master_len), 32'd3);
    check_val("rst_cnt", addrs_consumed | words_fetched | master_addr, 32'd0);
    reset = 1'b1;
    tick(2);

    // Basic fetch
    run_program = 1'b1; master_ready = 1'b1;
    addr_q.push_back(32'h0000_1000);
    wait_rd(20);
    check_val("basic_addr", master_addr, 32'h0000_1000);
    check_val("basic_len", 32'(master_len), 32'd3);
    tick(1);
    send_burst(32'h1122_3344, 4, -1);
    tick(3);
    check_val("basic_pops", 32'(n_pop), 32'd1);
    check_val("basic_consumed", addrs_consumed, 32'd1);
    check_val("basic_fetched", words_fetched, 32'd4);
    check_val("basic_err", 32'(fetch_error), 32'd0);

    // Byte swap with a five-cycle master stall
    vector_byte_swap = 1'b1; master_ready = 1'b0;
    addr_q.push_back(32'h0000_2000);
    wait_rd(20);
    for (int i = 0; i < 5; i++) begin
      check_val("stall_rd", 32'(master_rd), 32'd1);
      check_val("stall_addr", master_addr, 32'h0000_2000);
      tick(1);
    end
    master_ready = 1'b1;
    check_val("stall_rd6", 32'(master_rd), 32'd1);
    check_val("stall_addr6", master_addr, 32'h0000_2000);
    tick(1);
    send_burst(32'hAABB_CCDD, 4, -1);
    tick(3);
    vector_byte_swap = 1'b0;
    check_val("swap_fetched", words_fetched, 32'd8);

    // Throttle on vector-FIFO occupancy
    words_in_vctr_fifo = 16'd1021;
    addr_q.push_back(32'h0000_3000);
    tick(10);
    check_val("thr_no_pop", 32'(n_pop), 32'd2);
    check_val("thr_idle", 32'(fetch_busy), 32'd0);
    words_in_vctr_fifo = 16'd1020;
    tick(1);
    check_val("thr_pop", 32'(addr_fifo_rd), 32'd1);
    wait_rd(20);
    tick(1);
    send_burst(32'h0303_0303, 4, -1);
    tick(3);
    words_in_vctr_fifo = 16'd0;

    // Misaligned address
    addr_q.push_back(32'h0000_1002);
    saw_rd = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      saw_rd = saw_rd | master_rd;
    end
    check_val("mis_err", 32'(fetch_error), 32'd1);
    check_val("mis_no_rd", 32'(saw_rd), 32'd0);
    check_val("mis_idle", 32'(fetch_busy), 32'd0);
    check_val("mis_consumed", addrs_consumed, 32'd4);
    clear_error = 1'b1; tick(1); clear_error = 1'b0; tick(1);
    check_val("clr_err", 32'(fetch_error), 32'd0);

    // Stray beat in IDLE, then clear colliding with a new error
    master_data_in = 32'hDEAD_BEEF; master_data_in_val = 1'b1; tick(1);
    master_data_in_val = 1'b0; tick(2);
    check_val("stray_err", 32'(fetch_error), 32'd1);
    check_val("stray_fetched", words_fetched, 32'd12);
    clear_error = 1'b1; master_data_in_val = 1'b1; tick(1);
    clear_error = 1'b0; master_data_in_val = 1'b0; tick(1);
    check_val("set_wins", 32'(fetch_error), 32'd1);
    clear_error = 1'b1; tick(1); clear_error = 1'b0; tick(1);
    check_val("clr_err2", 32'(fetch_error), 32'd0);

    // run_program dropped after the first beat
    addr_q.push_back(32'h0000_5000);
    addr_q.push_back(32'h0000_6000);
    wait_rd(20);
    tick(1);
    send_burst(32'h5000_0001, 1, -1);
    run_program = 1'b0;
    send_burst(32'h5111_1112, 3, -1);
    tick(10);
    check_val("drop_idle", 32'(fetch_busy), 32'd0);
    check_val("drop_pops", 32'(n_pop), 32'd5);
    check_val("drop_fetched", words_fetched, 32'd16);
    check_val("drop_pending", 32'(addr_fifo_empty), 32'd0);

    // Beat into a full vector FIFO still counts toward the burst
    run_program = 1'b1;
    wait_rd(20);
    tick(1);
    send_burst(32'h6000_0000, 4, 1);
    tick(3);
    check_val("full_err", 32'(fetch_error), 32'd1);
    check_val("full_fetched", words_fetched, 32'd19);
    check_val("full_idle", 32'(fetch_busy), 32'd0);
    clear_error = 1'b1; tick(1); clear_error = 1'b0;

    // Reset during DATA, then a beat arriving after release
    addr_q.push_back(32'h0000_7000);
    wait_rd(20);
    tick(1);
    send_burst(32'h7000_0000, 1, -1);
    #3 reset = 1'b0;
    #1;
    check_val("mrst_busy", 32'(fetch_busy), 32'd0);
    check_val("mrst_wr", 32'(vctr_fifo_wr), 32'd0);
    check_val("mrst_din", vctr_fifo_din, 32'd0);
    check_val("mrst_addr", master_addr, 32'd0);
    check_val("mrst_cnt", addrs_consumed | words_fetched, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    tick(1);
    master_data_in = 32'h0BAD_0BAD; master_data_in_val = 1'b1; tick(1);
    master_data_in_val = 1'b0; tick(2);
    check_val("late_err", 32'(fetch_error), 32'd1);
    check_val("late_fetched", words_fetched, 32'd0);
    check_val("total_pops", 32'(n_pop), 32'd7);
    check_val("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
